// File: rtl/counter_sequencer_pkg.sv
// Shared types and default widths for the counter sequencer controller.
package counter_sequencer_pkg;

    localparam int unsigned DEF_WIDTH      = 4;
    localparam int unsigned DEF_PRESCALE_W = 8;
    localparam int unsigned DEF_PERIODS_W  = 8;

    typedef enum logic [1:0] {
        OP_START_ONESHOT  = 2'd0,
        OP_START_PERIODIC = 2'd1,
        OP_STOP           = 2'd2,
        OP_CLEAR          = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    typedef enum logic {
        MODE_ONESHOT  = 1'b0,
        MODE_PERIODIC = 1'b1
    } mode_e;

    function automatic logic is_start(input op_e op);
        return (op == OP_START_ONESHOT) || (op == OP_START_PERIODIC);
    endfunction

endpackage

// File: rtl/counter_sequencer_if.sv
// Command port of the counter sequencer: valid/ready handshake plus opcode and start fields.
interface counter_sequencer_if
    import counter_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned PRESCALE_W = DEF_PRESCALE_W
);
    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic [1:0]            cmd_op_i;
    logic [WIDTH-1:0]      cmd_target_i;
    logic [PRESCALE_W-1:0] cmd_prescale_i;

    modport master (
        output cmd_valid_i, cmd_op_i, cmd_target_i, cmd_prescale_i,
        input  cmd_ready_o
    );

    modport slave (
        input  cmd_valid_i, cmd_op_i, cmd_target_i, cmd_prescale_i,
        output cmd_ready_o
    );
endinterface

// File: rtl/counter_sequencer_prescaler.sv
// Reloading down-counter; tick is high while the remaining count is zero.
module counter_sequencer_prescaler
    import counter_sequencer_pkg::*;
#(
    parameter int unsigned PRESCALE_W = DEF_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  count,
    input  logic [PRESCALE_W-1:0] load_value,
    output logic                  tick
);
    logic [PRESCALE_W-1:0] remaining;

    // Counting down from prescale to 0 matches an up-count 0..prescale ticking at the top.
    always_ff @(posedge clk) begin
        if (rst) begin
            remaining <= '0;
        end else if (load) begin
            remaining <= load_value;
        end else if (count) begin
            if (remaining == '0) begin
                remaining <= load_value;
            end else begin
                remaining <= remaining - PRESCALE_W'(1);
            end
        end
    end

    assign tick = (remaining == '0);
endmodule

// File: rtl/counter_sequencer.sv
// Command-driven sequencer for an enable-gated up-counter with prescaled enables and terminal stop.
module counter_sequencer
    import counter_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned PRESCALE_W = DEF_PRESCALE_W,
    parameter int unsigned PERIODS_W  = DEF_PERIODS_W
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    counter_sequencer_if.slave   cmd,
    input  logic [WIDTH-1:0]     counter_value_i,
    output logic                 counter_enable_o,
    output logic                 counter_clear_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [PERIODS_W-1:0] periods_o
);
    state_e                state, state_d;
    logic                  start_pending, start_pending_d;
    mode_e                 mode_q;
    logic [WIDTH-1:0]      target_q;
    logic [PRESCALE_W-1:0] prescale_q;
    logic [PERIODS_W-1:0]  periods_q;

    op_e  op;
    logic ready;
    logic accept;
    logic start_cmd;
    logic at_target;
    logic tick;

    assign op        = op_e'(cmd.cmd_op_i);
    assign ready     = !reset_i && (state != ST_CLEAR);
    assign accept    = cmd.cmd_valid_i && ready;
    assign start_cmd = accept && is_start(op);
    assign at_target = (state == ST_RUN) && (counter_value_i == target_q);

    assign cmd.cmd_ready_o  = ready;
    assign done_o           = !reset_i && at_target;
    assign counter_enable_o = !reset_i && (state == ST_RUN) && !at_target && tick;
    assign counter_clear_o  = reset_i || (state == ST_CLEAR);
    assign busy_o           = !reset_i && (state != ST_IDLE);
    assign periods_o        = periods_q;

    counter_sequencer_prescaler #(
        .PRESCALE_W(PRESCALE_W)
    ) u_prescaler (
        .clk        (clock_i),
        .rst        (reset_i),
        .load       (state == ST_CLEAR),
        .count      (state == ST_RUN),
        .load_value (prescale_q),
        .tick       (tick)
    );

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state         <= ST_IDLE;
            start_pending <= 1'b0;
        end else begin
            state         <= state_d;
            start_pending <= start_pending_d;
        end
    end

    // An accepted command always overrides the terminal-count mode transition.
    always_comb begin
        state_d         = state;
        start_pending_d = start_pending;
        case (state)
            ST_IDLE: begin
                if (start_cmd) begin
                    state_d         = ST_CLEAR;
                    start_pending_d = 1'b1;
                end else if (accept && op == OP_CLEAR) begin
                    state_d         = ST_CLEAR;
                    start_pending_d = 1'b0;
                end
            end
            ST_CLEAR: begin
                state_d         = start_pending ? ST_RUN : ST_IDLE;
                start_pending_d = 1'b0;
            end
            ST_RUN: begin
                if (start_cmd) begin
                    state_d         = ST_CLEAR;
                    start_pending_d = 1'b1;
                end else if (accept && op == OP_STOP) begin
                    state_d = ST_IDLE;
                end else if (accept && op == OP_CLEAR) begin
                    state_d         = ST_CLEAR;
                    start_pending_d = 1'b0;
                end else if (at_target) begin
                    if (mode_q == MODE_PERIODIC) begin
                        state_d         = ST_CLEAR;
                        start_pending_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d         = ST_IDLE;
                start_pending_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            mode_q     <= MODE_ONESHOT;
            target_q   <= '0;
            prescale_q <= '0;
            periods_q  <= '0;
        end else begin
            if (start_cmd) begin
                mode_q     <= (op == OP_START_PERIODIC) ? MODE_PERIODIC : MODE_ONESHOT;
                target_q   <= cmd.cmd_target_i;
                prescale_q <= cmd.cmd_prescale_i;
            end
            if (start_cmd) begin
                periods_q <= '0;
            end else if (done_o && periods_q != '1) begin
                periods_q <= periods_q + PERIODS_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: vector table, directed corner sequences and random commands vs a reference model.
module tb_counter_sequencer;
    import counter_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    counter_sequencer_if #(.WIDTH(4), .PRESCALE_W(8)) cmd_bus ();

    logic [3:0] cnt = '0;
    logic       en, clr, busy, done;
    logic [7:0] periods;

    counter_sequencer #(
        .WIDTH(4),
        .PRESCALE_W(8),
        .PERIODS_W(8)
    ) dut (
        .clock_i          (clk),
        .reset_i          (rst),
        .cmd              (cmd_bus),
        .counter_value_i  (cnt),
        .counter_enable_o (en),
        .counter_clear_o  (clr),
        .busy_o           (busy),
        .done_o           (done),
        .periods_o        (periods)
    );

    // The board counter being sequenced.
    always @(posedge clk) begin
        if (clr) cnt <= '0;
        else if (en) cnt <= cnt + 4'd1;
    end

    int total = 0;
    int bad = 0;

    // Reference model: phase 0 idle, 1 clear, 2 run; m_k counts RUN cycles since entry.
    int m_phase = 0, m_pend = 0, m_target = 0, m_pre = 0, m_periodic = 0;
    int m_k = 0, m_periods = 0, m_cnt = 0;
    int e_ready, e_en, e_clr, e_done, e_busy;

    typedef struct {
        bit r; bit v; int op; int t; int p;
        int ready; int en; int clr; int done; int busy; int per; int cnt;
    } vec_t;
    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_eval(input bit r);
        bit at;
        if (r) begin
            e_ready = 0; e_en = 0; e_clr = 1; e_done = 0; e_busy = 0;
        end else begin
            at     = (m_phase == 2) && (m_cnt == m_target);
            e_ready = (m_phase != 1);
            e_clr   = (m_phase == 1);
            e_busy  = (m_phase != 0);
            e_done  = at;
            e_en    = (m_phase == 2) && !at && ((m_k % (m_pre + 1)) == m_pre);
        end
    endtask

    task automatic model_advance(input bit r, input bit v, input int op, input int t, input int p);
        bit acc, st;
        if (r) begin
            m_cnt = 0; m_phase = 0; m_pend = 0; m_target = 0; m_pre = 0;
            m_periodic = 0; m_k = 0; m_periods = 0;
            return;
        end
        if (e_clr) m_cnt = 0;
        else if (e_en) m_cnt = (m_cnt + 1) % 16;
        acc = v && (e_ready != 0);
        st  = acc && (op < 2);
        if (st) m_periods = 0;
        else if (e_done && m_periods < 255) m_periods++;
        case (m_phase)
            0: begin
                if (st) begin m_phase = 1; m_pend = 1; end
                else if (acc && op == 3) begin m_phase = 1; m_pend = 0; end
            end
            1: begin
                m_phase = m_pend ? 2 : 0; m_pend = 0; m_k = 0;
            end
            default: begin
                m_k++;
                if (st) begin m_phase = 1; m_pend = 1; end
                else if (acc && op == 2) m_phase = 0;
                else if (acc && op == 3) begin m_phase = 1; m_pend = 0; end
                else if (e_done) begin
                    if (m_periodic) begin m_phase = 1; m_pend = 1; end
                    else m_phase = 0;
                end
            end
        endcase
        if (st) begin
            m_target = t; m_pre = p; m_periodic = (op == 1);
        end
    endtask

    task automatic step(input bit r, input bit v, input int op, input int t, input int p);
        @(negedge clk);
        rst = r;
        cmd_bus.cmd_valid_i    = v;
        cmd_bus.cmd_op_i       = op[1:0];
        cmd_bus.cmd_target_i   = t[3:0];
        cmd_bus.cmd_prescale_i = p[7:0];
        #1;
        model_eval(r);
        chk("ready", cmd_bus.cmd_ready_o, e_ready);
        chk("enable", en, e_en);
        chk("clear", clr, e_clr);
        chk("done", done, e_done);
        chk("busy", busy, e_busy);
        chk("periods", periods, m_periods);
        chk("count", cnt, m_cnt);
        model_advance(r, v, op, t, p);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0);
    endtask

    initial begin
        int last, lat;
        bit hit, prev_done;

        //              r v op t p   rdy en clr dn bsy per cnt
        vecs[0]  = '{1, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0};
        vecs[1]  = '{0, 1, 0, 3, 0,  1, 0, 0, 0, 0, 0, 0};
        vecs[2]  = '{0, 0, 0, 0, 0,  0, 0, 1, 0, 1, 0, 0};
        vecs[3]  = '{0, 0, 0, 0, 0,  1, 1, 0, 0, 1, 0, 0};
        vecs[4]  = '{0, 0, 0, 0, 0,  1, 1, 0, 0, 1, 0, 1};
        vecs[5]  = '{0, 0, 0, 0, 0,  1, 1, 0, 0, 1, 0, 2};
        vecs[6]  = '{0, 0, 0, 0, 0,  1, 0, 0, 1, 1, 0, 3};
        vecs[7]  = '{0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 1, 3};
        vecs[8]  = '{0, 1, 0, 5, 1,  1, 0, 0, 0, 0, 1, 3};
        vecs[9]  = '{0, 0, 0, 0, 0,  0, 0, 1, 0, 1, 0, 3};
        vecs[10] = '{0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 0, 0};
        vecs[11] = '{0, 0, 0, 0, 0,  1, 1, 0, 0, 1, 0, 0};
        vecs[12] = '{0, 1, 2, 0, 0,  1, 0, 0, 0, 1, 0, 1};
        vecs[13] = '{0, 1, 2, 0, 0,  1, 0, 0, 0, 0, 0, 1};
        vecs[14] = '{0, 1, 3, 0, 0,  1, 0, 0, 0, 0, 0, 1};
        vecs[15] = '{0, 0, 0, 0, 0,  0, 0, 1, 0, 1, 0, 1};
        vecs[16] = '{0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0};

        cmd_bus.cmd_valid_i    = 1'b0;
        cmd_bus.cmd_op_i       = 2'd0;
        cmd_bus.cmd_target_i   = '0;
        cmd_bus.cmd_prescale_i = '0;
        @(negedge clk);

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].r, vecs[i].v, vecs[i].op, vecs[i].t, vecs[i].p);
            chk($sformatf("vec%0d ready", i), cmd_bus.cmd_ready_o, vecs[i].ready);
            chk($sformatf("vec%0d enable", i), en, vecs[i].en);
            chk($sformatf("vec%0d clear", i), clr, vecs[i].clr);
            chk($sformatf("vec%0d done", i), done, vecs[i].done);
            chk($sformatf("vec%0d busy", i), busy, vecs[i].busy);
            chk($sformatf("vec%0d periods", i), periods, vecs[i].per);
            chk($sformatf("vec%0d count", i), cnt, vecs[i].cnt);
        end

        // Periodic target 2 prescale 1: done every 6 cycles, clear right after each done.
        step(0, 1, 1, 2, 1);
        last = -1;
        prev_done = 0;
        for (int c = 1; c <= 36; c++) begin
            idle();
            if (prev_done) chk("clear after done", clr, 1);
            if (done) begin
                if (last < 0) chk("first periodic done", c, 6);
                else chk("periodic spacing", c - last, 6);
                last = c;
            end
            prev_done = done;
        end
        chk("periods after 5 terminals", periods, 5);

        // One-shot start accepted in the periodic terminal cycle.
        hit = 0;
        for (int n = 0; n < 20; n++) begin
            model_eval(0);
            if (e_done) begin
                step(0, 1, 0, 1, 0);
                chk("done with start", done, 1);
                hit = 1;
                break;
            end
            idle();
        end
        chk("terminal reached", hit, 1);
        idle();
        chk("periods cleared", periods, 0);
        chk("clear after start", clr, 1);
        idle();
        chk("new run enable", en, 1);
        idle();
        chk("new target done", done, 1);
        chk("new target value", cnt, 1);
        idle();
        chk("oneshot back idle", busy, 0);

        // Saturation: target 0 periodic terminates every other cycle.
        step(0, 1, 1, 0, 0);
        for (int n = 0; n < 600; n++) idle();
        chk("periods saturated", periods, 255);
        step(0, 1, 2, 0, 0);
        step(0, 1, 2, 0, 0);
        idle();
        chk("stopped after saturation", busy, 0);

        // Target 0: immediate done with no enable.
        step(0, 1, 0, 0, 7);
        idle();
        idle();
        chk("target0 done", done, 1);
        chk("target0 enable", en, 0);
        idle();

        // Target 15, prescale 255: counter reaches 15 without wrapping.
        step(0, 1, 0, 15, 255);
        lat = -1;
        for (int n = 1; n <= 4000; n++) begin
            idle();
            if (done) begin
                lat = n;
                break;
            end
        end
        chk("target15 latency", lat, 3842);
        chk("target15 value", cnt, 15);
        idle();
        chk("target15 no wrap", cnt, 15);
        chk("target15 idle", busy, 0);

        // Reset pulsed mid-RUN with a command presented.
        step(0, 1, 1, 3, 0);
        for (int n = 0; n < 8; n++) idle();
        step(1, 1, 0, 5, 0);
        chk("reset clear", clr, 1);
        chk("reset ready", cmd_bus.cmd_ready_o, 0);
        step(1, 1, 0, 5, 0);
        chk("reset enable", en, 0);
        idle();
        chk("post-reset periods", periods, 0);
        chk("post-reset busy", busy, 0);
        chk("post-reset ready", cmd_bus.cmd_ready_o, 1);
        chk("post-reset clear", clr, 0);

        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 3)));
        end
        step(1, 0, 0, 0, 0);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/counter_sequencer.md
# counter_sequencer

Command-driven controller that sequences the board's 4-bit enable-gated up-counter. It accepts start/stop/clear commands over a valid/ready port and drives the counter's enable and clear inputs. Enables are divided by a programmable prescaler, and the controller stops or restarts at a programmable terminal value. It sits between the board's command source and the counter, which keeps its own datapath unchanged.

## Interface
Parameters:
- `WIDTH`, default 4: counter width; the width of `cmd_target_i` and `counter_value_i`.
- `PRESCALE_W`, default 8: prescaler width.
- `PERIODS_W`, default 8: width of the completed-period count.

Ports:
- `clock_i` in 1: single clock; all state changes on the rising edge.
- `reset_i` in 1: synchronous, active-high reset.
- `cmd_valid_i` in 1: a command is presented.
- `cmd_ready_o` out 1: the command is accepted on the edge where valid and ready are both high.
- `cmd_op_i` in 2: command opcode.
  - 0 = START_ONESHOT
  - 1 = START_PERIODIC
  - 2 = STOP
  - 3 = CLEAR
- `cmd_target_i` in WIDTH: terminal count; latched on START.
- `cmd_prescale_i` in PRESCALE_W: one enable is issued every `prescale+1` RUN cycles; latched on START.
- `counter_value_i` in WIDTH: registered value from the counter.
- `counter_enable_o` out 1: counter increment enable.
- `counter_clear_o` out 1: counter clear. The counter reads 0 after the edge where this is high.
- `busy_o` out 1: the controller is in CLEAR or RUN.
- `done_o` out 1: one-cycle pulse when the terminal count is reached.
- `periods_o` out PERIODS_W: number of completed periods since the last START; saturating.

## Operation
States: IDLE, CLEAR, RUN. `cmd_ready_o` is decoded from the state: 1 in IDLE and RUN, 0 in CLEAR.

IDLE:
- START_* latches target, prescale and mode, clears `periods_o`, goes to CLEAR.
- CLEAR goes to CLEAR and then returns to IDLE.
- STOP is accepted and has no effect.

CLEAR (one cycle):
- `counter_clear_o` = 1 and the prescaler resets to 0.
- Next state is RUN if a start is pending, otherwise IDLE.

RUN:
- The prescaler counts 0..prescale, then wraps to 0.
- `counter_enable_o` = (presc == prescale) && (counter_value_i != target).
- When `counter_value_i` == target:
  - `counter_enable_o` = 0 and `done_o` = 1 for that cycle.
  - `periods_o` increments, saturating at 2^PERIODS_W−1.
  - ONESHOT goes to IDLE; PERIODIC goes to CLEAR and then RUN again.
- STOP goes to IDLE; the counter holds its value and nothing is cleared.
- CLEAR goes to CLEAR and then IDLE.
- START_* relatches its fields and restarts through CLEAR; `periods_o` is cleared.

Simultaneous events:
- A command accepted in the terminal cycle: `done_o` and the `periods_o` increment still occur. The command's transition overrides the mode transition. A START in that cycle clears `periods_o`, and the clear takes priority over the increment.
- The counter wrapping past 2^WIDTH−1 is impossible while sequenced, because enable is blocked at target.

Target 0: the first RUN cycle raises `done_o` with no enable.

Reset (`reset_i` = 1, applied in any state, including mid-RUN):
- Next state IDLE; prescaler, latched fields and `periods_o` go to 0.
- `counter_clear_o` = 1 and `counter_enable_o` = 0 while reset is high.
- `done_o` = 0 and `busy_o` = 0.
- `cmd_ready_o` = 0 and commands are ignored while reset is high.
- After reset releases: `cmd_ready_o` = 1 and `counter_clear_o` = 0.

## Timing
- State, prescaler and `periods_o` are registers.
- `counter_enable_o`, `done_o` and `cmd_ready_o` are combinational from registers plus `counter_value_i`. `counter_value_i` comes from a register, so there is no combinational loop.
- START accepted at edge 0: CLEAR during cycle 1, first RUN cycle is cycle 2. With prescale 0, the first enable is in cycle 2.
- Worst-case one-shot latency from acceptance to `done_o` is 2 + (target)·(prescale+1) cycles.
- PERIODIC: `done_o` in cycle t gives CLEAR in t+1 and RUN again in t+2. Period = (target)·(prescale+1) + 2 cycles.
- Commands take effect on the edge of acceptance. No command buffering.

## Structure
- `counter_sequencer_pkg` holds:
  - the opcode enum (`OP_START_ONESHOT`, `OP_START_PERIODIC`, `OP_STOP`, `OP_CLEAR`);
  - the state enum;
  - the mode type;
  - default widths.
- Sub-module `counter_sequencer_prescaler`: `PRESCALE_W` down-counter with load, clear and a tick output. The FSM and compare logic stay in the top.

## Test plan
- Reset, then START_ONESHOT target=3 prescale=0 at edge 0 → clear in cycle 1; enables in cycles 2–4; `done_o` in cycle 5 with value 3; IDLE and ready in cycle 6; `periods_o`=1.
- START_PERIODIC target=2 prescale=1 → one enable every 2 cycles; `done_o` every 6 cycles; `counter_clear_o` the cycle after each `done_o`; `periods_o` counts 1, 2, 3…, saturating at 255 over a long run.
- STOP during RUN at value 1 → IDLE next edge; counter holds 1; no clear; `done_o` never pulses.
- START_ONESHOT accepted in the same cycle as a periodic terminal → `done_o`=1 that cycle, `periods_o` reads 0 afterwards, CLEAR follows, new target honored.
- Target 0 and target 15 with prescale 255 → immediate `done_o` at 0; counter reaches 15 without wrapping.
- `reset_i` pulsed mid-RUN with `cmd_valid_i` high → `counter_clear_o`=1 and ready=0 during reset; command dropped; IDLE with `periods_o`=0 after release.
